// File: rtl/hilo_ctrl_pkg.sv
// Shared MIPS definitions: EX op codes seen by the HI/LO issuer and the
// multiply/divide unit, FSM encodings and default unit latencies.
package mips_defs;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_MFHI  = 4'b0001;
    localparam logic [3:0] OP_MFLO  = 4'b0010;
    localparam logic [3:0] OP_MTHI  = 4'b0011;
    localparam logic [3:0] OP_MTLO  = 4'b0100;
    localparam logic [3:0] OP_MULT  = 4'b0101;
    localparam logic [3:0] OP_MULTU = 4'b0110;
    localparam logic [3:0] OP_DIVU  = 4'b0111;
    localparam logic [3:0] OP_DIV   = 4'b1011;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int unsigned DEF_MUL_LAT = 5;
    localparam int unsigned DEF_DIV_LAT = 29;
    localparam int unsigned CNT_W       = 6;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_md_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// EX-stage HI/LO owner: issues multiply/divide to an external multi-cycle
// unit, stalls while it runs, captures its result and serves MF/MT ops.
module hilo_ctrl
    import mips_defs::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [3:0]       ex_op,
    input  logic [WIDTH-1:0] ex_rs,
    input  logic [WIDTH-1:0] ex_rt,
    input  logic             flush,
    output logic             stall_o,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             md_start,
    output logic [3:0]       md_op,
    output logic [WIDTH-1:0] md_a,
    output logic [WIDTH-1:0] md_b,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             idle;
    logic             live;
    logic             issue;
    logic             last;
    logic             capture;
    logic             mt_hi;
    logic             mt_lo;

    assign idle    = (state == ST_IDLE);
    assign live    = ex_valid & ~flush;
    assign issue   = idle & live & is_md_op(ex_op);
    assign last    = ~idle & (cnt == CNT_ONE);
    assign capture = last & ~flush;
    assign mt_hi   = idle & live & (ex_op == OP_MTHI);
    assign mt_lo   = idle & live & (ex_op == OP_MTLO);

    // The final BUSY cycle (counter == 1) already has the result on md_hi/md_lo,
    // so the instruction retires there; a flush releases the pipeline at once.
    always_comb begin
        stall_o = 1'b0;
        if (!rst) begin
            if (idle) begin
                stall_o = issue;
            end else begin
                stall_o = ~flush & (cnt != CNT_ONE);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (ex_op)
            OP_MFHI: rd_data = hi_o;
            OP_MFLO: rd_data = lo_o;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            md_start <= 1'b0;
            md_op    <= '0;
            md_a     <= '0;
            md_b     <= '0;
        end else begin
            md_start <= 1'b0;
            if (idle) begin
                if (issue) begin
                    md_start <= 1'b1;
                    md_op    <= ex_op;
                    md_a     <= ex_rs;
                    md_b     <= ex_rt;
                    cnt      <= is_div_op(ex_op) ? DIV_CNT : MUL_CNT;
                    state    <= ST_BUSY;
                end
            end else if (flush || last) begin
                cnt   <= '0;
                state <= ST_IDLE;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (capture) begin
            hi_o <= md_hi;
            lo_o <= md_lo;
        end else begin
            if (mt_hi) hi_o <= ex_rs;
            if (mt_lo) lo_o <= ex_rs;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Randomized bench for hilo_ctrl with a behavioural multiply/divide unit and
// an architectural HI/LO model.
module tb_hilo_ctrl;
    import mips_defs::*;

    localparam int MUL_L = 5;
    localparam int DIV_L = 29;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_rs, ex_rt;
    logic        flush;
    logic        stall_o;
    logic [31:0] rd_data, hi_o, lo_o;
    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] md_a, md_b;
    logic [31:0] md_hi = '0, md_lo = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    hilo_ctrl #(.WIDTH(32), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .stall_o(stall_o),
        .rd_data(rd_data), .hi_o(hi_o), .lo_o(lo_o), .md_start(md_start),
        .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_hi(md_hi), .md_lo(md_lo)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [3:0] op);
        return (op == OP_DIV || op == OP_DIVU) ? DIV_L : MUL_L;
    endfunction

    function automatic bit is_md(input logic [3:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
    endfunction

    // {HI, LO} as the unit would return it; divide-by-zero gives {a, all ones}
    function automatic logic [63:0] unit_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] r;
        int q, rm;
        r = '0;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r = 64'(sa * sb);
            end
            OP_MULTU: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                r = ua * ub;
            end
            OP_DIVU: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            OP_DIV: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                else begin
                    q = $signed(a) / $signed(b);
                    rm = $signed(a) % $signed(b);
                    r = {32'(rm), 32'(q)};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Unit model: correct result only in its latency cycle, noise otherwise.
    int          u_age = 0;
    logic [3:0]  u_op = '0;
    logic [31:0] u_a = '0, u_b = '0;
    always @(posedge clk) begin
        #2;
        if (md_start) begin
            u_age = 1;
            u_op = md_op;
            u_a = md_a;
            u_b = md_b;
        end else if (u_age > 0 && u_age < 200) begin
            u_age++;
        end
        if (u_age > 0 && u_age == lat_of(u_op)) {md_hi, md_lo} = unit_result(u_op, u_a, u_b);
        else {md_hi, md_lo} = {$urandom, $urandom};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit fl);
        @(posedge clk);
        #1;
        ex_valid = v;
        ex_op = op;
        ex_rs = a;
        ex_rt = b;
        flush = fl;
    endtask

    // flush_at: -1 none, 0 flush in the issue cycle, k>0 flush in cycle k after issue
    task automatic run_md(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int flush_at);
        int lat, stop, pulses;
        bit iss, wr;
        logic [63:0] res;
        lat = lat_of(op);
        iss = v && is_md(op) && flush_at != 0;
        if (!iss) stop = 0;
        else if (flush_at > 0 && flush_at <= lat) stop = flush_at;
        else stop = lat;
        wr = iss && (stop == lat) && !(flush_at == lat);
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            drive(v, op, a, b, c == flush_at);
            @(negedge clk);
            check("stall", {63'd0, stall_o}, {63'd0, c < stop});
            if (md_start) pulses++;
            if (c == 1 && iss) begin
                check("md_start", {63'd0, md_start}, 64'd1);
                check("md_op", {60'd0, md_op}, {60'd0, op});
                check("md_ab", {md_a, md_b}, {a, b});
            end
            if (c >= stop) break;
        end
        drive(1'b0, OP_NONE, '0, '0, 1'b0);
        @(negedge clk);
        check("start_pulses", 64'(pulses), iss ? 64'd1 : 64'd0);
        check("start_low", {63'd0, md_start}, 64'd0);
        check("idle_stall", {63'd0, stall_o}, 64'd0);
        check("rd_none", {32'd0, rd_data}, 64'd0);
        if (wr) begin
            res = unit_result(op, a, b);
            m_hi = res[63:32];
            m_lo = res[31:0];
        end
        check("hilo", {hi_o, lo_o}, {m_hi, m_lo});
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] val, input bit fl);
        drive(1'b1, to_hi ? OP_MTHI : OP_MTLO, val, $urandom, fl);
        @(negedge clk);
        check("mt_stall", {63'd0, stall_o}, 64'd0);
        if (!fl) begin
            if (to_hi) m_hi = val;
            else m_lo = val;
        end
    endtask

    task automatic mf(input bit from_hi);
        drive(1'b1, from_hi ? OP_MFHI : OP_MFLO, $urandom, $urandom, 1'b0);
        @(negedge clk);
        check("mf_stall", {63'd0, stall_o}, 64'd0);
        check(from_hi ? "mfhi" : "mflo", {32'd0, rd_data}, {32'd0, from_hi ? m_hi : m_lo});
        check("mf_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    endtask

    initial begin
        logic [3:0] ops[4];
        logic [3:0] junk[6];
        logic [3:0] op;
        logic [31:0] a, b;
        int fa, sel;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        junk = '{4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1110, 4'b1111};

        rst = 1'b1;
        ex_valid = 1'b1;
        ex_op = OP_MULT;
        ex_rs = 32'd7;
        ex_rt = 32'd9;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_md", {md_start, 27'd0, md_op, md_a}, 64'd0);
        check("rst_b", {32'd0, md_b}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        ex_valid = 1'b0;
        ex_op = OP_NONE;
        rst = 1'b0;

        run_md(1'b1, OP_MULT, 32'hFFFFFFFD, 32'd5, -1);
        check("mult_const", {hi_o, lo_o}, {32'hFFFFFFFF, 32'hFFFFFFF1});
        mf(1'b1);

        run_md(1'b1, OP_DIVU, 32'd100, 32'd7, -1);
        check("divu_const", {hi_o, lo_o}, {32'd2, 32'd14});

        mt(1'b1, 32'h12345678, 1'b0);
        mt(1'b0, 32'h9ABCDEF0, 1'b0);
        mf(1'b1);
        mf(1'b0);
        check("mt_const", {hi_o, lo_o}, {32'h12345678, 32'h9ABCDEF0});

        run_md(1'b1, OP_DIV, 32'd1000, 32'd3, 10);
        check("div_flush_keep", {hi_o, lo_o}, {32'h12345678, 32'h9ABCDEF0});
        run_md(1'b1, OP_MULTU, 32'd3, 32'd4, -1);
        check("multu_const", {hi_o, lo_o}, {32'd0, 32'd12});

        run_md(1'b1, OP_MULT, 32'd11, 32'd13, MUL_L);
        run_md(1'b1, OP_DIVU, 32'd50, 32'd6, DIV_L);
        check("flush_capture", {hi_o, lo_o}, {32'd0, 32'd12});
        run_md(1'b1, OP_MULT, 32'd2, 32'd2, 0);
        mt(1'b1, 32'hDEADBEEF, 1'b1);
        mf(1'b1);

        // asynchronous reset in the middle of a multiply
        mt(1'b1, 32'hA5A5A5A5, 1'b0);
        drive(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
        drive(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
        drive(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_stall", {63'd0, stall_o}, 64'd0);
        check("arst_md", {md_start, 27'd0, md_op, md_a}, 64'd0);
        check("arst_hilo", {hi_o, lo_o}, 64'd0);
        ex_valid = 1'b0;
        ex_op = OP_NONE;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, OP_NONE, '0, '0, 1'b0);
            @(negedge clk);
            check("arst_nowrite", {hi_o, lo_o}, 64'd0);
        end

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            if (sel <= 4) begin
                op = ops[$urandom_range(0, 3)];
                fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat_of(op)) : -1;
                run_md($urandom_range(0, 7) != 0, op, a, b, fa);
            end else if (sel == 5) begin
                mt($urandom_range(0, 1) == 1, a, $urandom_range(0, 5) == 0);
            end else if (sel <= 7) begin
                mf($urandom_range(0, 1) == 1);
            end else if (sel == 8) begin
                run_md(1'b1, junk[$urandom_range(0, 5)], a, b, -1);
            end else begin
                run_md(1'b1, OP_NONE, a, b, -1);
            end
        end

        drive(1'b0, OP_NONE, '0, '0, 1'b0);
        @(negedge clk);
        check("final_hilo", {hi_o, lo_o}, {m_hi, m_lo});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
